// File: rtl/micro_sequencer.sv
// micro_sequencer: micro-program sequencer for the microprogrammed control unit.
// Owns the uPC, decodes the sequencing field of the current microinstruction and
// selects the next control-store address (fetch, next, dispatch 1/2, branch,
// conditional branch, call, return). Stalls on memory handshakes and on invalid
// dispatch ROM data, and parks at instruction boundaries on a halt request.
//
// Build option: MICRO_STACK_EN enables the STACK_DEPTH x ADDR_W micro-return
// stack. Without it, call acts as branch, return acts as fetch (including the
// halt check) and stack_err is constant low.
//
// Ports:
//   clk, rst_n                       clock, async active-low reset
//   start                            leave IDLE/HALT, begin at uPC 0
//   seq_ctrl, branch_addr, cond      sequencing field, target, branch condition
//   dispatch1_addr, dispatch2_addr   dispatch ROM outputs
//   opcode_valid                     dispatch ROM outputs valid
//   mem_wait, mem_ready              memory handshake
//   halt_req                         halt at next instruction boundary
//   upc, mux_sel                     registered address and last applied select
//   stall                            combinational: uPC held this cycle
//   running, halted, stack_err       status (stack_err sticky until reset)
module micro_sequencer #(
  parameter int ADDR_W      = 5,
  parameter int STACK_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [2:0]        seq_ctrl,
  input  logic [ADDR_W-1:0] branch_addr,
  input  logic              cond,
  input  logic [ADDR_W-1:0] dispatch1_addr,
  input  logic [ADDR_W-1:0] dispatch2_addr,
  input  logic              opcode_valid,
  input  logic              mem_wait,
  input  logic              mem_ready,
  input  logic              halt_req,
  output logic [ADDR_W-1:0] upc,
  output logic [2:0]        mux_sel,
  output logic              stall,
  output logic              running,
  output logic              halted,
  output logic              stack_err
);

  localparam logic [2:0] SEQ_FETCH = 3'b000;
  localparam logic [2:0] SEQ_NEXT  = 3'b001;
  localparam logic [2:0] SEQ_DISP1 = 3'b010;
  localparam logic [2:0] SEQ_DISP2 = 3'b011;
  localparam logic [2:0] SEQ_BR    = 3'b100;
  localparam logic [2:0] SEQ_CBR   = 3'b101;
  localparam logic [2:0] SEQ_CALL  = 3'b110;
  localparam logic [2:0] SEQ_RET   = 3'b111;

  typedef enum logic [1:0] {IDLE, RUN, WAIT, HALT} state_t;

  state_t            state;
  logic [2:0]        held_ctrl;
  logic [2:0]        ctrl;
  logic [2:0]        eff;
  logic              active;
  logic              mem_hold;
  logic              disp_hold;
  logic              halt_now;
  logic              advance;
  logic [ADDR_W-1:0] upc_inc;
  logic [ADDR_W-1:0] next_upc;
  logic [ADDR_W-1:0] ret_addr;
  logic              stk_full;
  logic              stk_empty;

  // While waiting on memory the uPC is frozen, so the field captured on entry
  // is the one applied when the handshake completes.
  assign ctrl    = (state == WAIT) ? held_ctrl : seq_ctrl;
  assign upc_inc = upc + 1'b1;
  assign active  = (state == RUN) || (state == WAIT);

  always_comb begin
    eff = ctrl;
`ifndef MICRO_STACK_EN
    if (ctrl == SEQ_CALL)     eff = SEQ_BR;
    else if (ctrl == SEQ_RET) eff = SEQ_FETCH;
`endif
  end

  assign mem_hold  = (state == RUN)  ? (mem_wait && !mem_ready) :
                     (state == WAIT) ? !mem_ready : 1'b0;
  assign disp_hold = ((eff == SEQ_DISP1) || (eff == SEQ_DISP2)) && !opcode_valid;
  assign halt_now  = (eff == SEQ_FETCH) && halt_req;
  assign stall     = active && (mem_hold || disp_hold);
  assign advance   = active && !mem_hold && !disp_hold && !halt_now;

`ifdef MICRO_STACK_EN
  localparam int SP_W  = $clog2(STACK_DEPTH + 1);
  localparam int IDX_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

  logic [ADDR_W-1:0] stk [STACK_DEPTH];
  logic [SP_W-1:0]   sp;
  logic [IDX_W-1:0]  top_idx;

  assign top_idx   = IDX_W'(sp - 1'b1);
  assign stk_full  = (sp == SP_W'(STACK_DEPTH));
  assign stk_empty = (sp == '0);
  assign ret_addr  = stk[top_idx];

  always_ff @(posedge clk) begin
    if (rst_n && advance && (eff == SEQ_CALL) && !stk_full)
      stk[sp[IDX_W-1:0]] <= upc_inc;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sp        <= '0;
      stack_err <= 1'b0;
    end else if (advance) begin
      if (eff == SEQ_CALL) begin
        if (stk_full) stack_err <= 1'b1;
        else          sp        <= sp + 1'b1;
      end else if (eff == SEQ_RET) begin
        if (stk_empty) stack_err <= 1'b1;
        else           sp        <= sp - 1'b1;
      end
    end
  end
`else
  assign stk_full  = 1'b0;
  assign stk_empty = 1'b1;
  assign ret_addr  = '0;
  // No stack storage: the flag is constant low whatever depth is configured.
  assign stack_err = (STACK_DEPTH < 0);
`endif

  always_comb begin
    next_upc = '0;
    unique case (eff)
      SEQ_FETCH: next_upc = '0;
      SEQ_NEXT:  next_upc = upc_inc;
      SEQ_DISP1: next_upc = dispatch1_addr;
      SEQ_DISP2: next_upc = dispatch2_addr;
      SEQ_BR:    next_upc = branch_addr;
      SEQ_CBR:   next_upc = cond ? branch_addr : upc_inc;
      SEQ_CALL:  next_upc = branch_addr;
      SEQ_RET:   next_upc = stk_empty ? '0 : ret_addr;
      default:   next_upc = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      upc       <= '0;
      mux_sel   <= '0;
      held_ctrl <= '0;
      running   <= 1'b0;
      halted    <= 1'b0;
    end else begin
      unique case (state)
        IDLE, HALT: begin
          if (start) begin
            state   <= RUN;
            running <= 1'b1;
            halted  <= 1'b0;
          end
        end
        RUN, WAIT: begin
          if (mem_hold) begin
            if (state == RUN) begin
              state     <= WAIT;
              held_ctrl <= seq_ctrl;
            end
          end else if (disp_hold) begin
            state <= RUN;
          end else if (halt_now) begin
            state   <= HALT;
            upc     <= '0;
            mux_sel <= ctrl;
            running <= 1'b0;
            halted  <= 1'b1;
          end else begin
            state   <= RUN;
            upc     <= next_upc;
            mux_sel <= ctrl;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_micro_sequencer.sv
module tb_micro_sequencer;
  localparam int AW = 5;
  localparam int SD = 4;
`ifdef MICRO_STACK_EN
  localparam bit STK = 1'b1;
`else
  localparam bit STK = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [2:0]    seq_ctrl = '0;
  logic [AW-1:0] branch_addr = '0;
  logic          cond = 1'b0;
  logic [AW-1:0] dispatch1_addr = '0;
  logic [AW-1:0] dispatch2_addr = '0;
  logic          opcode_valid = 1'b0;
  logic          mem_wait = 1'b0;
  logic          mem_ready = 1'b0;
  logic          halt_req = 1'b0;
  logic [AW-1:0] upc;
  logic [2:0]    mux_sel;
  logic          stall, running, halted, stack_err;

  always #5 clk = ~clk;

  micro_sequencer #(.ADDR_W(AW), .STACK_DEPTH(SD)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .seq_ctrl(seq_ctrl),
    .branch_addr(branch_addr), .cond(cond), .dispatch1_addr(dispatch1_addr),
    .dispatch2_addr(dispatch2_addr), .opcode_valid(opcode_valid),
    .mem_wait(mem_wait), .mem_ready(mem_ready), .halt_req(halt_req),
    .upc(upc), .mux_sel(mux_sel), .stall(stall), .running(running),
    .halted(halted), .stack_err(stack_err)
  );

  typedef struct {
    bit rst_n, start, cond, opv, mw, mr, hr;
    int seq, br, d1, d2;
  } stim_t;

  typedef struct {
    bit rst;
    bit stall;
    int upc, mux;
    bit run, halt, err;
  } exp_t;

  exp_t  sbq[$];
  stim_t nx;
  int    n_checks = 0;
  int    n_fail = 0;

  // Reference model: plain variables and a queue for the return stack.
  int m_upc, m_mux, m_held;
  bit m_run, m_wait, m_halt, m_err;
  int m_stack[$];

  task automatic chk(input string name, input int act, input int req);
    n_checks++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic model_reset();
    m_upc = 0; m_mux = 0; m_held = 0;
    m_run = 0; m_wait = 0; m_halt = 0; m_err = 0;
    m_stack.delete();
  endtask

  task automatic model_apply(input int s, input int eff);
    int inc;
    inc = (m_upc + 1) % (1 << AW);
    if (eff == 0 && nx.hr) begin
      m_upc = 0; m_mux = s; m_run = 0; m_halt = 1;
    end else begin
      m_mux = s;
      case (eff)
        0: m_upc = 0;
        1: m_upc = inc;
        2: m_upc = nx.d1;
        3: m_upc = nx.d2;
        4: m_upc = nx.br;
        5: m_upc = nx.cond ? nx.br : inc;
        6: begin
          if (m_stack.size() == SD) m_err = 1;
          else m_stack.push_back(inc);
          m_upc = nx.br;
        end
        default: begin
          if (m_stack.size() == 0) begin
            m_err = 1; m_upc = 0;
          end else m_upc = m_stack.pop_back();
        end
      endcase
    end
  endtask

  task automatic model_edge();
    exp_t e;
    int   s, eff;
    bit   disp;
    e.rst = !nx.rst_n;
    e.stall = 0;
    if (!nx.rst_n) begin
      model_reset();
    end else begin
      s = m_wait ? m_held : nx.seq;
      eff = s;
      if (!STK && s == 6) eff = 4;
      if (!STK && s == 7) eff = 0;
      disp = (eff == 2 || eff == 3) && !nx.opv;
      if (!m_run) begin
        if (nx.start) begin m_run = 1; m_halt = 0; end
      end else if (!m_wait && nx.mw && !nx.mr) begin
        e.stall = 1; m_wait = 1; m_held = nx.seq;
      end else if (m_wait && !nx.mr) begin
        e.stall = 1;
      end else begin
        m_wait = 0;
        if (disp) e.stall = 1;
        else model_apply(s, eff);
      end
    end
    e.upc = m_upc; e.mux = m_mux; e.run = m_run; e.halt = m_halt;
    e.err = STK ? m_err : 1'b0;
    sbq.push_back(e);
  endtask

  task automatic step(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      rst_n = nx.rst_n; start = nx.start; seq_ctrl = 3'(nx.seq);
      branch_addr = AW'(nx.br); cond = nx.cond;
      dispatch1_addr = AW'(nx.d1); dispatch2_addr = AW'(nx.d2);
      opcode_valid = nx.opv; mem_wait = nx.mw; mem_ready = nx.mr;
      halt_req = nx.hr;
      model_edge();
    end
  endtask

  task automatic op(input int seq, input int br, input int n);
    nx.seq = seq; nx.br = br;
    step(n);
  endtask

  // Monitor: pops one expectation per cycle; stall is checked mid-cycle with
  // the inputs applied, registered outputs just after the following edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (sbq.size() > 0) begin
        e = sbq.pop_front();
        chk("stall", int'(stall), int'(e.stall));
        if (e.rst) begin
          chk("async_rst_upc", int'(upc), 0);
          chk("async_rst_running", int'(running), 0);
        end
        @(posedge clk);
        #1;
        chk("upc", int'(upc), e.upc);
        chk("mux_sel", int'(mux_sel), e.mux);
        chk("running", int'(running), int'(e.run));
        chk("halted", int'(halted), int'(e.halt));
        chk("stack_err", int'(stack_err), int'(e.err));
      end
    end
  end

  initial begin
    model_reset();
    nx = '{rst_n: 1'b0, start: 1'b0, cond: 1'b0, opv: 1'b1, mw: 1'b0,
           mr: 1'b0, hr: 1'b0, seq: 0, br: 0, d1: 0, d2: 0};
    step(2);
    nx.rst_n = 1'b1;
    op(1, 0, 2);                 // IDLE ignores sequencing field
    nx.start = 1'b1; step(1);
    nx.start = 1'b0;
    op(1, 0, 33);                // 1..31, 0, 1 with wrap
    op(1, 0, 3);                 // upc = 4
    nx.opv = 1'b0; nx.d1 = 17;
    op(2, 0, 2);                 // dispatch hold
    nx.opv = 1'b1;
    op(2, 0, 1);                 // upc = 17
    op(4, 9, 1);                 // upc = 9
    nx.mw = 1'b1; nx.mr = 1'b0;
    nx.start = 1'b1;             // ignored while running
    op(1, 0, 3);
    nx.start = 1'b0; nx.mr = 1'b1;
    op(1, 0, 1);                 // upc = 10
    nx.mw = 1'b0; nx.mr = 1'b0;
    nx.hr = 1'b1;
    op(1, 0, 1);                 // not a boundary: no halt
    op(0, 0, 1);                 // halt
    nx.hr = 1'b0;
    op(1, 0, 2);                 // parked
    nx.start = 1'b1; step(1);
    nx.start = 1'b0;
    op(1, 0, 3);
    op(4, 3, 1);                 // upc = 3
    op(6, 20, 1);                // call
    op(7, 0, 1);                 // return -> 4
    for (int k = 0; k < 5; k++) op(6, 8 + k, 1);
    op(7, 0, 6);                 // unwind, then return on empty
    op(4, 2, 1);
    op(6, 10, 2);                // two stack entries
    nx.mw = 1'b1; nx.mr = 1'b0;
    op(1, 0, 2);                 // in WAIT
    nx.rst_n = 1'b0; step(1);
    nx.rst_n = 1'b1; nx.mw = 1'b0;
    step(1);
    nx.start = 1'b1; step(1);
    nx.start = 1'b0;
    op(7, 0, 1);                 // stack must be empty after reset
    op(1, 0, 2);

    for (int i = 0; i < 600; i++) begin
      nx.rst_n = ($urandom_range(0, 149) != 0);
      nx.start = ($urandom_range(0, 5) == 0);
      nx.seq   = $urandom_range(0, 7);
      nx.br    = $urandom_range(0, 31);
      nx.d1    = $urandom_range(0, 31);
      nx.d2    = $urandom_range(0, 31);
      nx.cond  = $urandom_range(0, 1) == 1;
      nx.opv   = $urandom_range(0, 3) != 0;
      nx.mw    = $urandom_range(0, 3) == 0;
      nx.mr    = $urandom_range(0, 1) == 1;
      nx.hr    = $urandom_range(0, 3) == 0;
      step(1);
    end

    nx.rst_n = 1'b1; nx.mw = 1'b0; nx.hr = 1'b0; nx.start = 1'b0;
    op(1, 0, 2);
    repeat (2) @(negedge clk);
    chk("scoreboard_drained", sbq.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/micro_sequencer.md
# micro_sequencer

Micro-program sequencer for the MIPS microprogrammed control unit. It owns the micro-program counter (uPC), decodes the sequencing field of the current microinstruction, and selects the next control-store address: fetch, increment, dispatch 1, dispatch 2, branch, call or return. It also stalls on memory handshakes and parks the control unit at instruction boundaries on a halt request. It sits between the control-store ROM output and the control-store address input.

## Interface

- ADDR_W, 5, micro-address width
- STACK_DEPTH, 4, micro-return stack entries (used only with MICRO_STACK_EN)

- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  leave IDLE/HALT and begin at uPC 0
- seq_ctrl  in  3  sequencing field of current microinstruction
- branch_addr  in  ADDR_W  branch/call target field of current microinstruction
- cond  in  1  branch condition from datapath
- dispatch1_addr  in  ADDR_W  dispatch ROM 1 output
- dispatch2_addr  in  ADDR_W  dispatch ROM 2 output
- opcode_valid  in  1  dispatch ROM outputs are valid
- mem_wait  in  1  current microinstruction waits on memory
- mem_ready  in  1  memory handshake complete
- halt_req  in  1  request halt at next instruction boundary
- upc  out  ADDR_W  registered control-store address
- mux_sel  out  3  registered select applied at last uPC update
- stall  out  1  combinational; uPC held this cycle
- running  out  1  state is RUN or WAIT
- halted  out  1  state is HALT
- stack_err  out  1  sticky stack overflow/underflow flag

## Operation

- seq_ctrl encoding / next uPC:
  - 000 fetch: 0
  - 001 next: upc+1, modulo 2^ADDR_W (31 -> 0)
  - 010 dispatch1: dispatch1_addr
  - 011 dispatch2: dispatch2_addr
  - 100 branch: branch_addr
  - 101 cond branch: cond ? branch_addr : upc+1
  - 110 call: push upc+1, goto branch_addr
  - 111 return: pop
- mux_sel is loaded with seq_ctrl on every uPC update and holds during stalls.
- States:
  - IDLE: upc=0; start -> RUN.
  - RUN: one uPC update per cycle.
  - WAIT: hold upc until mem_ready, then apply the held seq_ctrl and return to RUN.
  - HALT: upc=0; start -> RUN.
- RUN priority, highest first:
  - mem_wait && !mem_ready -> WAIT, hold.
  - seq_ctrl=010/011 && !opcode_valid -> hold in RUN, stall=1.
  - seq_ctrl=000 && halt_req -> HALT, upc=0.
  - Otherwise, normal update.
- mem_wait && mem_ready in the same cycle: no stall; update normally.
- halt_req is ignored unless seq_ctrl=000 (instruction boundary).
- Stack:
  - Call on full: push dropped, branch taken, stack_err set.
  - Return on empty: upc=0, stack_err set.
  - stack_err clears only on reset.

## Timing

- Reset values:
  - upc=0, mux_sel=000, state IDLE
  - running=0, halted=0, stack_err=0, stall=0
  - stack empty
- Reset is effective immediately on rst_n low, including mid-WAIT or with the stack partially full.
- All inputs are sampled on the rising clk edge. The new upc is visible the same edge, giving one cycle per microinstruction.
- start while in RUN or WAIT is ignored.
- stall is high in WAIT while mem_ready=0, and during a dispatch hold. It is low in IDLE and HALT.
- running/halted update on the same edge as the state transition.

## Configuration

- MICRO_STACK_EN defined:
  - A STACK_DEPTH x ADDR_W LIFO implements call/return as described above.
- MICRO_STACK_EN undefined:
  - No stack storage.
  - 110 behaves as 100 (branch).
  - 111 behaves as 000 (fetch, including halt check).
  - stack_err tied 0.

## Test plan

- Reset, then start; seq_ctrl=001 for 33 cycles -> upc 0,1,…,31,0,1; mux_sel=001.
- At upc=4: seq_ctrl=010, opcode_valid=0 for 2 cycles, then 1 with dispatch1_addr=17 -> upc holds 4 with stall=1 for 2 cycles, then upc=17.
- seq_ctrl=001, mem_wait=1, mem_ready=0 for 3 cycles at upc=9 -> WAIT, upc=9, stall=1; mem_ready=1 -> upc=10, running=1 throughout.
- halt_req=1 while seq_ctrl=001 -> no halt; then seq_ctrl=000 -> halted=1, upc=0; start -> RUN, upc advances from 0.
- With MICRO_STACK_EN: call from upc=3 to 20, return -> upc 20 then 4. Five nested calls -> stack_err=1, fifth return address lost. Return on empty -> upc=0.
- Assert rst_n low during WAIT with 2 stack entries -> immediately upc=0, IDLE, stack empty, stack_err=0.
